fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences the 256x9 instruction memory.
//  Two jobs: load a program into memory through a ready/valid beat stream,
//  then fetch one instruction per cycle with stall, branch and halt handling.
//  Sits between the top-level control/loader and instruction memory.
//  Drives the memory read address and the memory write port.
// PARAMETERS
//  PC_W       8            pc / memory address width (depth = 2**PC_W)
//  INSTR_W    9            instruction word width
//  START_PC   0            pc loaded on every entry to RUN
//  HALT_WORD  9'h1FF       instruction encoding that ends execution
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst_n        in   1        asynchronous reset, active-low
//  start        in   1        begin execution (IDLE/DONE only)
//  load_en      in   1        request/hold program-load mode
//  load_valid   in   1        load beat valid
//  load_data    in   INSTR_W  load beat instruction word
//  load_last    in   1        final beat of program
//  load_ready   out  1        sequencer accepts load beat
//  load_ovf     out  1        sticky: load write address wrapped
//  mem_we       out  1        instruction memory write enable
//  mem_waddr    out  PC_W     instruction memory write address
//  mem_wdata    out  INSTR_W  instruction memory write data
//  pc           out  PC_W     instruction memory read address
//  instr_in     in   INSTR_W  instruction memory read data (comb. read)
//  instr_out    out  INSTR_W  fetched instruction to decode
//  instr_valid  out  1        instr_out valid this cycle
//  stall        in   1        downstream hold; freezes pc
//  br_taken     in   1        redirect fetch this cycle
//  br_target    in   PC_W     absolute branch destination
//  busy         out  1        state is LOAD or RUN
//  done         out  1        state is DONE
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, mem_waddr=0, load_ovf=0. mem_we, load_ready,
//   instr_valid, busy and done are all 0. Reset mid-load or mid-run aborts
//   immediately; words already written stay in memory.
//  States: IDLE, LOAD, RUN, DONE. load_en has priority over start.
//  IDLE/DONE:
//   - load_en=1 -> LOAD; mem_waddr<=0; load_ovf<=0.
//   - else start=1 -> RUN; pc<=START_PC.
//  LOAD:
//   - load_ready=1.
//   - Beat = load_valid&load_ready. mem_we is comb. = beat;
//     mem_wdata=load_data at mem_waddr.
//   - mem_waddr++ per beat; 255->0 wraps and sets load_ovf.
//   - beat&load_last -> IDLE; mem_waddr is then the word count (mod 256).
//   - load_en=0 -> IDLE (abort); a beat in the same cycle is still written.
//  RUN:
//   - Memory read is comb.: instr_out=instr_in, instr_valid=~stall.
//   - stall=1: pc holds; br_taken ignored.
//   - else halt word presented (instr_valid=1 that cycle) -> DONE; pc holds.
//     Halt beats br_taken.
//   - else br_taken: pc<=br_target; else pc<=pc+1, 255->0 wraps silently.
//   - start and load_en are ignored in RUN.
//  Outputs outside RUN: instr_valid=0, instr_out=0. pc holds its last value.
//  Outside LOAD: mem_we=0, load_ready=0.
// CONFIGURATION
//  FETCH_RETIRE_CNT_EN defined:
//   - adds port retire_cnt out 16: count of cycles with instr_valid=1
//     (halt word included).
//   - Cleared on entry to RUN and on reset; saturates at 16'hFFFF;
//     held in DONE.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Load 4 beats 0x001,0x002,0x003,0x1FF (last on 4th) -> mem_we 4 cycles,
//     addr 0..3, IDLE, mem_waddr=4, load_ovf=0.
//  2. start after test 1 -> pc 0,1,2,3; instr_valid 4 cycles;
//     done=1 cycle 5; pc stays 3.
//  3. RUN, br_taken with br_target=0x80 while stall=1 -> pc holds.
//     Repeat with stall=0 -> next pc=0x80.
//  4. Halt word at pc with br_taken=1 -> DONE; pc not redirected.
//  5. Load 257 beats -> last word at addr 0, load_ovf=1.
//     rst_n low mid-RUN -> all outputs at reset values asynchronously.
//  6. FETCH_RETIRE_CNT_EN defined: program of 5 words plus halt
//     -> retire_cnt=6 in DONE. A second start clears it to 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program counter and instruction-memory sequencer: streams a program into memory, then fetches
// one instruction per cycle. Optional retire counter enabled by FETCH_RETIRE_CNT_EN.
module fetch_sequencer #(
  parameter int unsigned          PC_W      = 8,
  parameter int unsigned          INSTR_W   = 9,
  parameter logic [PC_W-1:0]      START_PC  = '0,
  parameter logic [INSTR_W-1:0]   HALT_WORD = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               load_en,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_ovf,
  output logic               mem_we,
  output logic [PC_W-1:0]    mem_waddr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               busy,
  output logic               done
`ifdef FETCH_RETIRE_CNT_EN
  ,
  output logic [15:0]        retire_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   waddr_q, waddr_d;
  logic              ovf_q, ovf_d;
  logic              beat;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    waddr_d     = waddr_q;
    ovf_d       = ovf_q;
    load_ready  = 1'b0;
    beat        = 1'b0;
    mem_we      = 1'b0;
    instr_valid = 1'b0;
    instr_out   = '0;
    unique case (state_q)
      StIdle, StDone: begin
        if (load_en) begin
          state_d = StLoad;
          waddr_d = '0;
          ovf_d   = 1'b0;
        end else if (start) begin
          state_d = StRun;
          pc_d    = START_PC;
        end
      end
      StLoad: begin
        load_ready = 1'b1;
        beat       = load_valid;
        mem_we     = beat;
        if (beat) begin
          waddr_d = waddr_q + PC_W'(1);
          if (waddr_q == '1) ovf_d = 1'b1;
        end
        // An abort still commits a beat offered in the same cycle.
        if ((beat && load_last) || !load_en) state_d = StIdle;
      end
      StRun: begin
        instr_out   = instr_in;
        instr_valid = !stall;
        if (!stall) begin
          // Halt wins over a branch presented alongside it.
          if (instr_in == HALT_WORD) begin
            state_d = StDone;
          end else if (br_taken) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      waddr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      waddr_q <= waddr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pc        = pc_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = load_data;
  assign load_ovf  = ovf_q;
  assign busy      = (state_q == StLoad) || (state_q == StRun);
  assign done      = (state_q == StDone);

`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] rc_q, rc_d;

  always_comb begin
    rc_d = rc_q;
    if (state_q != StRun && state_d == StRun) begin
      rc_d = '0;
    end else if (instr_valid && rc_q != 16'hFFFF) begin
      rc_d = rc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rc_q <= '0;
    else        rc_q <= rc_d;
  end

  assign retire_cnt = rc_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a behavioural memory and fetch model.
module tb_fetch_sequencer;
  localparam logic [8:0] HALT = 9'h1FF;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, load_en = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic       stall = 1'b0, br_taken = 1'b0;
  logic [8:0] load_data = '0;
  logic [7:0] br_target = '0;
  logic       load_ready, load_ovf, mem_we, instr_valid, busy, done;
  logic [7:0] mem_waddr, pc;
  logic [8:0] mem_wdata, instr_in, instr_out;
`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  logic [8:0] mem     [256] = '{default: '0};
  logic [8:0] ref_mem [256] = '{default: '0};
  logic [8:0] ld_q [$];
  int tests_run = 0, tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign instr_in = mem[pc];

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_en(load_en), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready), .load_ovf(load_ovf),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .pc(pc),
    .instr_in(instr_in), .instr_out(instr_out), .instr_valid(instr_valid), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .busy(busy), .done(done)
`ifdef FETCH_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  task automatic load_prog();
    logic [7:0] a = 8'd0;
    @(negedge clk); load_en = 1'b1;
    for (int i = 0; i < ld_q.size(); i++) begin
      @(negedge clk);
      load_valid = 1'b1; load_data = ld_q[i]; load_last = (i == ld_q.size() - 1);
      ref_mem[a] = ld_q[i]; a++;
    end
    @(negedge clk); load_valid = 1'b0; load_last = 1'b0; load_en = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({pc, mem_waddr} !== 16'h0) begin
      tests_failed++; $display("FAIL reset_addr: got %h want 0000", {pc, mem_waddr});
    end
    tests_run++;
    if ({load_ovf, mem_we, load_ready, instr_valid, busy, done} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 000000",
               {load_ovf, mem_we, load_ready, instr_valid, busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_basic();
    logic [8:0] w [4] = '{9'h001, 9'h002, 9'h003, 9'h1FF};
    @(negedge clk); load_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_valid = 1'b1; load_data = w[i]; load_last = (i == 3); ref_mem[i] = w[i];
      #1;
      tests_run++;
      if ({mem_we, load_ready, mem_waddr, mem_wdata} !== {2'b11, 8'(i), w[i]}) begin
        tests_failed++;
        $display("FAIL load_beat%0d: we/rdy/addr/data got %b %b %h %h want 1 1 %h %h", i,
                 mem_we, load_ready, mem_waddr, mem_wdata, 8'(i), w[i]);
      end
    end
    @(negedge clk); load_valid = 1'b0; load_last = 1'b0; load_en = 1'b0;
    #1;
    tests_run++;
    if ({busy, mem_we, load_ovf, mem_waddr} !== {3'b000, 8'd4}) begin
      tests_failed++;
      $display("FAIL load_end: busy/we/ovf/waddr got %b %b %b %h want 0 0 0 04",
               busy, mem_we, load_ovf, mem_waddr);
    end
    tests_run++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== {w[0], w[1], w[2], w[3]}) begin
      tests_failed++; $display("FAIL load_mem: got %h %h %h %h", mem[0], mem[1], mem[2], mem[3]);
    end
  endtask

  task automatic test_run_basic();
    start_run();
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if ({pc, instr_valid, instr_out, busy} !== {8'(i), 1'b1, ref_mem[i], 1'b1}) begin
        tests_failed++;
        $display("FAIL run_fetch%0d: pc/valid/instr got %h %b %h want %h 1 %h", i, pc,
                 instr_valid, instr_out, 8'(i), ref_mem[i]);
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if ({done, busy, instr_valid, pc, instr_out} !== {3'b100, 8'd3, 9'd0}) begin
      tests_failed++;
      $display("FAIL run_done: done/busy/valid/pc/instr got %b %b %b %h %h want 1 0 0 03 000",
               done, busy, instr_valid, pc, instr_out);
    end
  endtask

  task automatic test_halt_branch();
    ld_q = '{HALT};
    load_prog();
    start_run();
    br_taken = 1'b1; br_target = 8'h80;
    #1;
    tests_run++;
    if ({instr_valid, instr_out} !== {1'b1, HALT}) begin
      tests_failed++; $display("FAIL halt_fetch: got %b %h want 1 1ff", instr_valid, instr_out);
    end
    @(negedge clk); br_taken = 1'b0;
    #1;
    tests_run++;
    if ({done, pc} !== {1'b1, 8'h00}) begin
      tests_failed++; $display("FAIL halt_beats_branch: done/pc got %b %h want 1 00", done, pc);
    end
  endtask

  task automatic test_abort();
    logic [8:0] d;
    @(negedge clk); load_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d = 9'($urandom_range(0, 510));
      load_valid = 1'b1; load_data = d; ref_mem[i] = d;
      if (i == 2) load_en = 1'b0;
      #1;
      tests_run++;
      if (mem_we !== 1'b1) begin
        tests_failed++; $display("FAIL abort_we%0d: got %b want 1", i, mem_we);
      end
    end
    @(negedge clk); load_valid = 1'b0;
    #1;
    tests_run++;
    if ({load_ready, busy, load_ovf, mem_waddr, mem[2]} !== {3'b000, 8'd3, ref_mem[2]}) begin
      tests_failed++;
      $display("FAIL abort_end: rdy/busy/ovf/waddr/mem2 got %b %b %b %h %h want 0 0 0 03 %h",
               load_ready, busy, load_ovf, mem_waddr, mem[2], ref_mem[2]);
    end
  endtask

  task automatic test_load_wrap();
    ld_q.delete();
    for (int i = 0; i < 257; i++) ld_q.push_back(9'($urandom_range(0, 510)));
    load_prog();
    #1;
    tests_run++;
    if ({load_ovf, mem_waddr, mem[0]} !== {1'b1, 8'd1, ld_q[256]}) begin
      tests_failed++;
      $display("FAIL wrap: ovf/waddr/mem0 got %b %h %h want 1 01 %h", load_ovf, mem_waddr,
               mem[0], ld_q[256]);
    end
  endtask

  task automatic test_random_load_run();
    int n = $urandom_range(6, 20), i = 0, bad = 0;
    logic v;
    logic [8:0] d;
    logic [7:0] m_pc = 8'd0;
    bit m_done = 1'b0;
    @(negedge clk); load_en = 1'b1;
    for (int cyc = 0; cyc < 200 && i < n; cyc++) begin
      @(negedge clk);
      v = 1'($urandom_range(0, 1));
      d = (i == n - 1) ? HALT : 9'($urandom_range(0, 510));
      load_valid = v; load_data = d; load_last = (i == n - 1);
      #1;
      tests_run++;
      if ({mem_we, mem_waddr} !== {v, 8'(i)}) begin
        tests_failed++;
        $display("FAIL rload_beat: we/waddr got %b %h want %b %h", mem_we, mem_waddr, v, 8'(i));
      end
      if (v) begin ref_mem[i] = d; i++; end
    end
    @(negedge clk); load_valid = 1'b0; load_last = 1'b0; load_en = 1'b0;
    #1;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
    tests_run++;
    if (bad != 0 || mem_waddr !== 8'(n)) begin
      tests_failed++;
      $display("FAIL rload_mem: bad words %0d waddr %h want 0 %h", bad, mem_waddr, 8'(n));
    end
    start_run();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (m_done) break;
      stall = ($urandom_range(0, 3) == 0); br_taken = ($urandom_range(0, 3) == 0);
      br_target = 8'($urandom_range(0, n - 1));
      start = 1'($urandom_range(0, 1)); load_en = 1'($urandom_range(0, 1));
      #1;
      tests_run++;
      if ({pc, instr_valid, instr_out, busy} !== {m_pc, !stall, ref_mem[m_pc], 1'b1}) begin
        tests_failed++;
        $display("FAIL rrun_c%0d: pc/valid/instr got %h %b %h want %h %b %h", cyc, pc,
                 instr_valid, instr_out, m_pc, !stall, ref_mem[m_pc]);
      end
      if (!stall) begin
        if (ref_mem[m_pc] == HALT) m_done = 1'b1;
        else if (br_taken)         m_pc = br_target;
        else                       m_pc = m_pc + 8'd1;
      end
      @(negedge clk);
    end
    start = 1'b0; load_en = 1'b0; stall = 1'b0; br_taken = 1'b0;
    #1;
    tests_run++;
    if ({done, pc} !== {1'b1, m_pc}) begin
      tests_failed++; $display("FAIL rrun_end: done/pc got %b %h want 1 %h", done, pc, m_pc);
    end
  endtask

  task automatic test_stall_branch();
    ld_q = '{9'h010, 9'h011, 9'h012, 9'h013};
    load_prog();
    start_run();
    stall = 1'b1; br_taken = 1'b1; br_target = 8'h80;
    #1;
    tests_run++;
    if ({instr_valid, instr_out} !== {1'b0, 9'h010}) begin
      tests_failed++;
      $display("FAIL stall_valid: valid/instr got %b %h want 0 010", instr_valid, instr_out);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (pc !== 8'h00) begin
      tests_failed++; $display("FAIL stall_hold: pc got %h want 00", pc);
    end
    stall = 1'b0;
    @(negedge clk); br_taken = 1'b0;
    #1;
    tests_run++;
    if (pc !== 8'h80) begin
      tests_failed++; $display("FAIL branch: pc got %h want 80", pc);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL areset_pre: busy got %b want 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pc, mem_waddr, load_ovf, mem_we, load_ready, instr_valid, busy, done} !== 22'h0) begin
      tests_failed++;
      $display("FAIL areset: pc/waddr %h %h flags %b want 00 00 000000", pc, mem_waddr,
               {load_ovf, mem_we, load_ready, instr_valid, busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

`ifdef FETCH_RETIRE_CNT_EN
  task automatic test_retire();
    ld_q = '{9'h021, 9'h022, 9'h023, 9'h024, 9'h025, HALT};
    load_prog();
    start_run();
    for (int cyc = 0; cyc < 20 && !done; cyc++) @(negedge clk);
    #1;
    tests_run++;
    if ({done, retire_cnt} !== {1'b1, 16'd6}) begin
      tests_failed++; $display("FAIL retire_cnt: done/cnt got %b %0d want 1 6", done, retire_cnt);
    end
    start_run();
    #1;
    tests_run++;
    if (retire_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL retire_clear: got %0d want 0", retire_cnt);
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_load_basic();
    test_run_basic();
    test_halt_branch();
    test_abort();
    test_load_wrap();
    test_random_load_run();
    test_stall_branch();
    test_async_reset();
`ifdef FETCH_RETIRE_CNT_EN
    test_retire();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
